// File: rtl/dense_layer_stream.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_stream
// Purpose  : Time-multiplexed streaming dense layer. Each beat broadcasts one
//            signed activation to Engines MAC lanes, and each lane has its own
//            weight. After input_count beats every lane adds its bias,
//            arithmetic-shifts the sum, optionally applies ReLU and saturates
//            to N bits. The result vector leaves on a valid/ready port.
// Ports    : clk_i/rst_i          clock, synchronous active-high reset
//            start_i + config     pass configuration, latched on start in IDLE
//            act_valid_i/act_ready_o, act_i, weight_i   beat input stream
//            bias_i               per-lane 2N-bit bias, sampled in BIAS
//            dense_valid_o/dense_ready_i, dense_o        result vector
//            busy_o, done_o       status; done_o pulses after the handshake
// Revision : 1.0 - initial release
// ============================================================================
module dense_layer_stream #(
    parameter int N       = 16,
    parameter int Engines = 8,
    parameter int CountW  = 12,
    parameter int ShiftW  = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [CountW-1:0]            input_count_i,
    input  logic [$clog2(Engines+1)-1:0] engine_count_i,
    input  logic [ShiftW-1:0]            shift_i,
    input  logic [ShiftW-1:0]            shift_final_i,
    input  logic                         relu_en_i,
    input  logic                         act_valid_i,
    output logic                         act_ready_o,
    input  logic [N-1:0]                 act_i,
    input  logic [Engines*N-1:0]         weight_i,
    input  logic [Engines*2*N-1:0]       bias_i,
    output logic                         busy_o,
    output logic                         dense_valid_o,
    input  logic                         dense_ready_i,
    output logic [Engines*N-1:0]         dense_o,
    output logic                         done_o
);

    localparam int EW = $clog2(Engines+1);
    localparam int AW = 2*N;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_BIAS   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CountW-1:0]   beat_q, beat_d;
    logic                done_q, done_d;

    // Pass configuration, captured when a pass starts.
    logic [CountW-1:0]   count_q;
    logic [EW-1:0]       ecount_q;
    logic [ShiftW-1:0]   shift_q;
    logic [ShiftW-1:0]   shift_final_q;
    logic                relu_q;

    logic                w_load;
    logic                w_beat;
    logic [CountW-1:0]   w_beat_next;

    assign w_load      = (state_q == S_IDLE) && start_i;
    assign w_beat      = (state_q == S_ACCUM) && act_valid_i;
    assign w_beat_next = beat_q + 1'b1;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    beat_d  = '0;
                    state_d = (input_count_i == '0) ? S_BIAS : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (act_valid_i) begin
                    beat_d = w_beat_next;
                    if (w_beat_next == count_q) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (dense_ready_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            done_q        <= 1'b0;
            count_q       <= '0;
            ecount_q      <= '0;
            shift_q       <= '0;
            shift_final_q <= '0;
            relu_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            if (w_load) begin
                count_q       <= input_count_i;
                ecount_q      <= engine_count_i;
                shift_q       <= shift_i;
                shift_final_q <= shift_final_i;
                relu_q        <= relu_en_i;
            end
        end
    end

    assign act_ready_o   = (state_q == S_ACCUM);
    assign busy_o        = (state_q != S_IDLE);
    assign dense_valid_o = (state_q == S_OUTPUT);
    assign done_o        = done_q;

    for (genvar k = 0; k < Engines; k++) begin : g_lane
        localparam logic [EW-1:0] LANE_IDX = EW'(k);

        logic signed [N-1:0]  w_act;
        logic signed [N-1:0]  w_weight;
        logic signed [AW-1:0] w_bias;
        logic signed [AW-1:0] w_prod;
        logic signed [AW-1:0] w_prod_sh;
        logic signed [AW-1:0] w_sum;
        logic signed [AW-1:0] w_sum_sh;
        logic signed [AW-1:0] w_relu;
        logic signed [N-1:0]  w_sat;
        logic                 w_lane_en;
        logic signed [AW-1:0] acc_q, acc_d;
        logic signed [N-1:0]  res_q, res_d;

        assign w_lane_en = (LANE_IDX < ecount_q);
        assign w_act     = act_i;
        assign w_weight  = weight_i[k*N +: N];
        assign w_bias    = bias_i[k*AW +: AW];

        // Full-precision signed product, then per-product arithmetic shift.
        assign w_prod    = AW'(w_act) * AW'(w_weight);
        assign w_prod_sh = w_prod >>> shift_q;

        assign w_sum     = acc_q + w_bias;
        assign w_sum_sh  = w_sum >>> shift_final_q;
        assign w_relu    = (relu_q && w_sum_sh[AW-1]) ? '0 : w_sum_sh;

        always_comb begin
            if (w_relu > SAT_MAX) begin
                w_sat = SAT_MAX[N-1:0];
            end else if (w_relu < SAT_MIN) begin
                w_sat = SAT_MIN[N-1:0];
            end else begin
                w_sat = w_relu[N-1:0];
            end
        end

        // Disabled lanes hold their accumulator so they do not toggle.
        always_comb begin
            acc_d = acc_q;
            if (w_load) begin
                acc_d = '0;
            end else if (w_beat && w_lane_en) begin
                acc_d = acc_q + w_prod_sh;
            end
        end

        always_comb begin
            res_d = res_q;
            if (state_q == S_BIAS) begin
                res_d = w_lane_en ? w_sat : '0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                acc_q <= '0;
                res_q <= '0;
            end else begin
                acc_q <= acc_d;
                res_q <= res_d;
            end
        end

        assign dense_o[k*N +: N] = res_q;
    end

endmodule
`default_nettype wire

// File: doc/dense_layer_stream.md
Name: dense_layer_stream

Overview:
Time-multiplexed, streaming successor to the parallel dense layer. One activation per beat is broadcast to `Engines` MAC lanes, and each lane receives its own weight. Each lane accumulates over `input_count` beats, then adds a per-lane bias, applies an arithmetic shift, optional ReLU and N-bit saturation. The result vector is presented on a valid/ready output port. The block sits between the activation buffer/weight ROM and the next layer's input FIFO.

Parameters:
N, 16, activation/weight/output width (signed)
Engines, 8, number of parallel MAC lanes (output neurons per pass)
CountW, 12, width of the input-count configuration
ShiftW, 6, width of the per-product and final shift amounts

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  begin a pass; sampled only in IDLE
input_count_i  in  CountW  number of activation beats per pass; latched on start
engine_count_i  in  $clog2(Engines+1)  active lanes; lanes >= this output 0; latched on start
shift_i  in  ShiftW  arithmetic right shift applied to each product; latched on start
shift_final_i  in  ShiftW  arithmetic right shift applied to (acc+bias); latched on start
relu_en_i  in  1  clamp negative results to 0; latched on start
act_valid_i  in  1  activation/weight beat valid
act_ready_o  out  1  block accepts a beat (high only in ACCUM)
act_i  in  N  signed activation, broadcast to all lanes
weight_i  in  Engines x N  signed per-lane weight, qualified by act_valid_i
bias_i  in  Engines x 2N  signed per-lane bias; sampled in BIAS state
busy_o  out  1  high in any state other than IDLE
dense_valid_o  out  1  result vector valid
dense_ready_i  in  1  downstream accepts result
dense_o  out  Engines x N  signed result vector
done_o  out  1  one-cycle pulse on result handshake

Behaviour:
- Reset: state=IDLE; all accumulators, beat counter and dense_o = 0; act_ready_o, busy_o, dense_valid_o, done_o = 0. Reset mid-pass aborts the pass with no output, and partial sums are discarded.
- States:
  - IDLE: when start_i=1, latch the configuration and clear accumulators and the beat counter. Go to BIAS if input_count_i=0, else ACCUM.
  - ACCUM: act_ready_o=1. Each beat with act_valid_i=1 performs acc[k] += (act_i*weight_i[k]) >>> shift. The product is full 2N signed, shifted arithmetically, and the accumulator is 2N bits wrapping two's-complement. The beat counter increments per beat. The accepting beat that makes count == input_count goes to BIAS, and the accumulator holds that beat's sum in the BIAS cycle. If act_valid_i=0 the state stalls with nothing changing.
  - BIAS (1 cycle): sum = acc + bias_i[k] (2N wrap); s = sum >>> shift_final. If relu and s<0 then s=0. Saturate s to [-2^(N-1), 2^(N-1)-1]. Lanes k >= engine_count force 0. Register the result into dense_o and go to OUTPUT.
  - OUTPUT: dense_valid_o=1; dense_o stable until the handshake. When dense_ready_i=1: pulse done_o for one cycle (the cycle after the handshake) and go to IDLE.
- start_i outside IDLE is ignored. start_i in the same cycle as done_o (IDLE reached) is accepted.
- Latency, input_count=C with no stalls: first beat accepted in the cycle after start; dense_valid_o asserted C+2 cycles after start.
- Disabled lanes never update their accumulators, which removes switching power.
- Shift values >= 2N yield 0 or -1 (pure arithmetic-shift semantics).
- The block is purely parameter-generic: no lane count or width is hard-coded.

Test Plan:
- N=16, Engines=4, count=3, shifts 0, bias 0. Acts 1,2,3; lane0 weights 1,1,1, lane1 weights 2,2,2 -> dense_o={6,12,...}, dense_valid_o at cycle start+5.
- Saturation/ReLU: act 300, weight 300, count=1, shift_final=0 -> lane output 32767. Weight -300 -> -32768. With relu_en=1 the weight -300 case gives 0.
- Stall and backpressure: act_valid_i toggled 1,0,0,1, count=2 -> sum correct. Hold dense_ready_i=0 for 5 cycles -> dense_o stable, a start_i issued in that window is ignored, and done_o pulses once after ready.
- count=0, bias lane0=1024, shift_final=2 -> output 256 with no beats consumed (act_ready_o never high).
- engine_count=2 of 4, all weights 5, act 1, count=1 -> lanes {5,5,0,0}.
- rst_i asserted mid-ACCUM -> next cycle IDLE, outputs 0. A following pass with count=1, act 2, weight 3 gives 6, with no residue from the aborted pass.
